// File: rtl/rv_pkg.sv
// Shared types for the RV32 pipeline MEM stage: FSM states, exception causes, MEM/WB record.
package rv_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } mem_state_t;

    typedef enum logic [1:0] {
        EXC_NONE   = 2'd0,
        EXC_MIS_LD = 2'd1,
        EXC_MIS_ST = 2'd2,
        EXC_BUS    = 2'd3
    } exc_cause_t;

    typedef struct packed {
        logic [XLEN-1:0] read_data;
        logic [XLEN-1:0] alu_result;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_to_reg;
        logic            exc_valid;
        exc_cause_t      exc_cause;
    } memwb_t;

endpackage

// File: rtl/mem_stage_mem_wb.sv
// MEM/WB pipeline register; a bubble clears the whole record so nothing reaches write-back.
module mem_wb
    import rv_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   bubble,
    input  memwb_t d,
    output memwb_t q
);

    // Capture the next MEM/WB record, or a cleared bubble while the stage is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (bubble) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: alignment check, data-bus handshake FSM, stall generation and MEM/WB register.
module mem_stage
    import rv_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] write_data_in,
    input  logic [4:0]        rd_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              reg_write_in,
    input  logic              mem_to_reg_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_err,
    output logic              stall_o,
    output logic [DATA_W-1:0] read_data_out,
    output logic [ADDR_W-1:0] alu_result_out,
    output logic [4:0]        rd_out,
    output logic              reg_write_out,
    output logic              mem_to_reg_out,
    output logic              exc_valid_out,
    output logic [1:0]        exc_cause_out
);

    mem_state_t state, state_next;
    memwb_t     wb_d, wb_q;

    logic mem_op, is_load, is_store, misaligned, aligned_op;
    logic req_c, done;

    // A simultaneous read and write is treated as a load.
    assign mem_op     = mem_read_in | mem_write_in;
    assign is_load    = mem_read_in;
    assign is_store   = mem_write_in & ~mem_read_in;
    assign misaligned = mem_op & (alu_result_in[1:0] != 2'b00);
    assign aligned_op = mem_op & ~misaligned;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, bus request and completion decode.
    always_comb begin
        state_next = state;
        req_c      = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (aligned_op) begin
                    req_c = 1'b1;
                    if (dmem_gnt) begin
                        if (is_load) state_next = RESP;
                        else         done       = 1'b1;
                    end else begin
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                req_c = 1'b1;
                if (dmem_gnt) begin
                    if (is_load) begin
                        state_next = RESP;
                    end else begin
                        done       = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            RESP: begin
                if (dmem_rvalid) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Reset gating makes the request and stall fall immediately, even mid-access.
    assign dmem_req   = req_c & ~reset;
    assign stall_o    = (aligned_op | (state != IDLE)) & ~done & ~reset;
    assign dmem_we    = is_store;
    assign dmem_addr  = {alu_result_in[ADDR_W-1:2], 2'b00};
    assign dmem_wdata = write_data_in;

    // Assemble the MEM/WB record for the current EX/MEM contents.
    always_comb begin
        wb_d            = '0;
        wb_d.alu_result = alu_result_in;
        wb_d.rd         = rd_in;
        wb_d.mem_to_reg = mem_to_reg_in;
        if (misaligned) begin
            wb_d.exc_valid = 1'b1;
            wb_d.exc_cause = is_load ? EXC_MIS_LD : EXC_MIS_ST;
        end else if (done) begin
            if (dmem_err) begin
                wb_d.exc_valid = 1'b1;
                wb_d.exc_cause = EXC_BUS;
            end else begin
                wb_d.reg_write = reg_write_in;
                if (is_load) wb_d.read_data = dmem_rdata;
            end
        end else begin
            wb_d.reg_write = reg_write_in;
        end
    end

    mem_wb u_mem_wb (
        .clk    (clk),
        .reset  (reset),
        .bubble (stall_o),
        .d      (wb_d),
        .q      (wb_q)
    );

    assign read_data_out  = wb_q.read_data;
    assign alu_result_out = wb_q.alu_result;
    assign rd_out         = wb_q.rd;
    assign reg_write_out  = wb_q.reg_write;
    assign mem_to_reg_out = wb_q.mem_to_reg;
    assign exc_valid_out  = wb_q.exc_valid;
    assign exc_cause_out  = wb_q.exc_cause;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: single-cycle vector table plus hand-written bus sequences.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_result_in, write_data_in;
    logic [4:0]  rd_in;
    logic        mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_gnt, dmem_rvalid, dmem_err;
    logic [31:0] dmem_rdata;
    logic        stall_o;
    logic [31:0] read_data_out, alu_result_out;
    logic [4:0]  rd_out;
    logic        reg_write_out, mem_to_reg_out, exc_valid_out;
    logic [1:0]  exc_cause_out;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .alu_result_in(alu_result_in), .write_data_in(write_data_in), .rd_in(rd_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .dmem_err(dmem_err),
        .stall_o(stall_o),
        .read_data_out(read_data_out), .alu_result_out(alu_result_out), .rd_out(rd_out),
        .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
        .exc_valid_out(exc_valid_out), .exc_cause_out(exc_cause_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        mr, mw, rw, m2r;
        logic        e_rw, e_exc;
        logic [1:0]  e_cause;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mkv(logic [31:0] alu, logic [4:0] rd, logic mr, logic mw, logic rw,
                                 logic m2r, logic e_rw, logic e_exc, logic [1:0] e_cause);
        vec_t v;
        v.alu = alu; v.rd = rd; v.mr = mr; v.mw = mw; v.rw = rw; v.m2r = m2r;
        v.e_rw = e_rw; v.e_exc = e_exc; v.e_cause = e_cause;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                          input logic mr, input logic mw, input logic rw, input logic m2r);
        alu_result_in = alu; write_data_in = wd; rd_in = rd;
        mem_read_in = mr; mem_write_in = mw; reg_write_in = rw; mem_to_reg_in = m2r;
    endtask

    task automatic bus(input logic gnt, input logic rv, input logic [31:0] rdat, input logic err);
        dmem_gnt = gnt; dmem_rvalid = rv; dmem_rdata = rdat; dmem_err = err;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic chk_wb(input string name, input logic [31:0] rdata, input logic [31:0] alu,
                          input logic [4:0] rd, input logic rw, input logic m2r,
                          input logic exc, input logic [1:0] cause);
        chk({name, ".read_data"}, read_data_out, rdata);
        chk({name, ".alu_result"}, alu_result_out, alu);
        chk({name, ".rd"}, {27'd0, rd_out}, {27'd0, rd});
        chk({name, ".wb_ctl"}, {29'd0, reg_write_out, mem_to_reg_out, exc_valid_out},
            {29'd0, rw, m2r, exc});
        chk({name, ".cause"}, {30'd0, exc_cause_out}, {30'd0, cause});
    endtask

    initial begin
        int stalls, reqs;

        vecs[0] = mkv(32'h0000_1234, 5'd5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        vecs[1] = mkv(32'hFFFF_FFFF, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        vecs[2] = mkv(32'h0000_0202, 5'd3,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1);
        vecs[3] = mkv(32'h0000_0101, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
        vecs[4] = mkv(32'h0000_0203, 5'd9,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1);
        vecs[5] = mkv(32'h0000_0ABC, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

        reset = 1'b1;
        set_in(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus(1'b0, 1'b0, 32'd0, 1'b0);
        tick; tick;
        mid;
        chk("reset.req_stall", {30'd0, dmem_req, stall_o}, 32'd0);
        chk_wb("reset", 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        tick;
        reset = 1'b0;

        // Single-cycle vectors: ALU ops and misaligned accesses never request or stall.
        for (int unsigned i = 0; i < 6; i++) begin
            set_in(vecs[i].alu, 32'h5555_AAAA, vecs[i].rd, vecs[i].mr, vecs[i].mw,
                   vecs[i].rw, vecs[i].m2r);
            mid;
            chk($sformatf("vec%0d.req_stall", i), {30'd0, dmem_req, stall_o}, 32'd0);
            tick;
            chk_wb($sformatf("vec%0d", i), 32'd0, vecs[i].alu, vecs[i].rd, vecs[i].e_rw,
                   vecs[i].m2r, vecs[i].e_exc, vecs[i].e_cause);
        end

        // Store with grant held off for two cycles.
        set_in(32'h0000_0100, 32'hDEAD_BEEF, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        stalls = 0; reqs = 0;
        for (int unsigned c = 0; c < 3; c++) begin
            bus(c == 2, 1'b0, 32'd0, 1'b0);
            mid;
            if (dmem_req) reqs++;
            if (stall_o) stalls++;
            chk($sformatf("st.bus%0d", c), dmem_addr ^ dmem_wdata ^ {31'd0, dmem_we},
                32'h0000_0100 ^ 32'hDEAD_BEEF ^ 32'd1);
            tick;
            if (c < 2) chk($sformatf("st.bubble%0d", c), {30'd0, reg_write_out, exc_valid_out}, 32'd0);
        end
        chk("st.req_cycles", reqs, 3);
        chk("st.stall_cycles", stalls, 2);
        chk_wb("st.done", 32'd0, 32'h0000_0100, 5'd4, 1'b0, 1'b0, 1'b0, 2'd0);
        bus(1'b0, 1'b0, 32'd0, 1'b0);

        // Load with immediate grant, response three cycles later.
        set_in(32'h0000_0200, 32'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
        stalls = 0;
        for (int unsigned c = 0; c < 4; c++) begin
            bus(c == 0, c == 3, (c == 3) ? 32'hCAFE_F00D : 32'h1111_1111, 1'b0);
            mid;
            if (stall_o) stalls++;
            if (c == 0) chk("ld.req", {30'd0, dmem_req, dmem_we}, 32'd2);
            if (c == 1) chk("ld.resp_noreq", {31'd0, dmem_req}, 32'd0);
            tick;
        end
        chk("ld.stall_cycles", stalls, 3);
        chk_wb("ld.done", 32'hCAFE_F00D, 32'h0000_0200, 5'd7, 1'b1, 1'b1, 1'b0, 2'd0);

        // Load completing with a bus error.
        set_in(32'h0000_0300, 32'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
        bus(1'b1, 1'b0, 32'd0, 1'b0);
        tick;
        bus(1'b0, 1'b1, 32'h2222_2222, 1'b1);
        mid;
        chk("lderr.stall", {31'd0, stall_o}, 32'd0);
        tick;
        chk("lderr.wb", {28'd0, reg_write_out, exc_valid_out, exc_cause_out}, {28'd0, 1'b0, 1'b1, 2'd3});

        // Stray response and grant while idle with an ALU op held steady.
        set_in(32'h0000_0055, 32'd0, 5'd10, 1'b0, 1'b0, 1'b1, 1'b0);
        bus(1'b0, 1'b0, 32'd0, 1'b0);
        tick;
        bus(1'b1, 1'b1, 32'h3333_3333, 1'b1);
        mid;
        chk("stray.req_stall", {30'd0, dmem_req, stall_o}, 32'd0);
        tick;
        chk_wb("stray", 32'd0, 32'h0000_0055, 5'd10, 1'b1, 1'b0, 1'b0, 2'd0);

        // Zero-wait store with bus error, then a back-to-back zero-wait store.
        set_in(32'h0000_0500, 32'h1234_5678, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        bus(1'b1, 1'b0, 32'd0, 1'b1);
        mid;
        chk("sterr.req_stall", {30'd0, dmem_req, stall_o}, 32'd2);
        tick;
        chk("sterr.wb", {28'd0, reg_write_out, exc_valid_out, exc_cause_out}, {28'd0, 1'b0, 1'b1, 2'd3});
        set_in(32'h0000_0504, 32'h8765_4321, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        bus(1'b1, 1'b0, 32'd0, 1'b0);
        mid;
        chk("b2b.req_stall", {30'd0, dmem_req, stall_o}, 32'd2);
        chk("b2b.addr", dmem_addr, 32'h0000_0504);
        tick;
        chk("b2b.wb", {29'd0, reg_write_out, exc_valid_out, 1'b0}, 32'd0);

        // Reset asserted while waiting for a load response.
        set_in(32'h0000_0400, 32'd0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1);
        bus(1'b1, 1'b0, 32'd0, 1'b0);
        tick;
        bus(1'b0, 1'b0, 32'd0, 1'b0);
        mid;
        chk("rst.pre_stall", {31'd0, stall_o}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("rst.req_stall", {30'd0, dmem_req, stall_o}, 32'd0);
        chk_wb("rst.async", 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        set_in(32'h0000_0ABC, 32'd0, 5'd12, 1'b0, 1'b0, 1'b1, 1'b0);
        tick;
        reset = 1'b0;
        bus(1'b0, 1'b1, 32'h4444_4444, 1'b0);
        mid;
        chk("rst.late_rvalid", {30'd0, dmem_req, stall_o}, 32'd0);
        tick;
        bus(1'b0, 1'b0, 32'd0, 1'b0);
        chk_wb("rst.after", 32'd0, 32'h0000_0ABC, 5'd12, 1'b1, 1'b0, 1'b0, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
